// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
//============================================================================
package mem_port_arbiter_pkg;

    // Default busy-cycle count at which the timeout flag sets
    localparam int c_timeout_default = 20;
    // Default and widest supported address width (width of req_t.addr)
    localparam int c_aw_default      = 32;
    localparam int c_aw_max          = 32;
    // Data bus width
    localparam int c_dw              = 32;
    // Width of the saturating busy-cycle counter
    localparam int c_cnt_w           = 5;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One requester's command as seen by the arbiter
    typedef struct packed {
        logic                rd;
        logic                wr;
        logic [c_aw_max-1:0] addr;
        logic [c_dw-1:0]     wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the two requester ports, the memory-system port
//               and the arbiter status signals.
// Revision    : 1.0 - initial release
//============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    // Port 0 (fetch)
    logic          p0_rd;
    logic          p0_wr;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata;
    logic [31:0]   p0_rdata;
    logic          p0_done;
    logic          p0_hit;
    // Port 1 (data)
    logic          p1_rd;
    logic          p1_wr;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata;
    logic [31:0]   p1_rdata;
    logic          p1_done;
    logic          p1_hit;
    // Memory system
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic          mem_stall;
    logic          mem_hit;
    // Status
    logic          grant;
    logic          busy;
    logic          err_timeout;
    logic          err_proto;

    // Arbiter side
    modport slave (
        input  p0_rd, p0_wr, p0_addr, p0_wdata,
        output p0_rdata, p0_done, p0_hit,
        input  p1_rd, p1_wr, p1_addr, p1_wdata,
        output p1_rdata, p1_done, p1_hit,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_done, mem_stall, mem_hit,
        output grant, busy, err_timeout, err_proto
    );

    // Environment side: requesters plus memory system
    modport master (
        output p0_rd, p0_wr, p0_addr, p0_wdata,
        input  p0_rdata, p0_done, p0_hit,
        output p1_rd, p1_wr, p1_addr, p1_wdata,
        input  p1_rdata, p1_done, p1_hit,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_done, mem_stall, mem_hit,
        input  grant, busy, err_timeout, err_proto
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
//============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin winner select. A lone requester wins;
//               on a tie the port that was not granted last wins.
// Revision    : 1.0 - initial release
//============================================================================
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_winner,
    output logic o_valid
);

    // Pick the winner from the two request bits and the previous owner
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = 1'b0;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_grant;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory-system port between
//               a fetch port (0) and a data port (1). One transaction is in
//               flight at a time; completion is routed back combinationally.
// Revision    : 1.0 - initial release
//============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default,
    parameter int AW      = c_aw_default
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    state_t               r_state;
    state_t               w_state_nxt;

    req_t                 w_req0;
    req_t                 w_req1;
    req_t                 w_sel;
    logic                 w_winner;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_done;

    logic                 r_last_grant;
    logic                 r_grant;
    logic                 r_rd;
    logic                 r_wr;
    logic [AW-1:0]        r_addr;
    logic [c_dw-1:0]      r_wdata;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_to_hit;
    logic                 r_err_timeout;
    logic                 r_err_proto;

    // Gather each requester's command into the common request record
    always_comb begin
        w_req0       = '0;
        w_req0.rd    = bus.p0_rd;
        w_req0.wr    = bus.p0_wr;
        w_req0.addr  = c_aw_max'(bus.p0_addr);
        w_req0.wdata = bus.p0_wdata;
        w_req1       = '0;
        w_req1.rd    = bus.p1_rd;
        w_req1.wr    = bus.p1_wr;
        w_req1.addr  = c_aw_max'(bus.p1_addr);
        w_req1.wdata = bus.p1_wdata;
    end

    rr_pick2 u_pick (
        .i_req0       (w_req0.rd | w_req0.wr),
        .i_req1       (w_req1.rd | w_req1.wr),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_valid      (w_any)
    );

    // Winner's command, acceptance and completion qualifiers
    always_comb begin
        w_sel     = w_winner ? w_req1 : w_req0;
        w_accept  = (r_state == IDLE) && !bus.mem_stall && w_any;
        w_done    = (r_state == BUSY) && bus.mem_done;
        w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        w_to_hit  = (32'(w_cnt_inc) == 32'(TIMEOUT));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and all bus-facing outputs
    always_comb begin
        w_state_nxt     = r_state;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.p0_done     = 1'b0;
        bus.p0_rdata    = '0;
        bus.p0_hit      = 1'b0;
        bus.p1_done     = 1'b0;
        bus.p1_rdata    = '0;
        bus.p1_hit      = 1'b0;
        bus.busy        = 1'b0;
        bus.grant       = r_last_grant;
        bus.err_timeout = r_err_timeout;
        bus.err_proto   = r_err_proto;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                bus.busy      = 1'b1;
                bus.grant     = r_grant;
                bus.mem_rd    = r_rd;
                bus.mem_wr    = r_wr;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = r_wdata;
                // Completion and read data go only to the owner, only while done
                if (!r_grant) begin
                    bus.p0_done  = bus.mem_done;
                    bus.p0_rdata = bus.mem_done ? bus.mem_rdata : '0;
                    bus.p0_hit   = bus.mem_done & bus.mem_hit;
                end else begin
                    bus.p1_done  = bus.mem_done;
                    bus.p1_rdata = bus.mem_done ? bus.mem_rdata : '0;
                    bus.p1_hit   = bus.mem_done & bus.mem_hit;
                end
                if (bus.mem_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Transaction capture, owner history, busy counter and sticky errors
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
            r_err_proto   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_winner;
                r_rd    <= w_sel.rd;
                // A simultaneous rd+wr is demoted to a plain read
                r_wr    <= w_sel.wr & ~w_sel.rd;
                r_addr  <= AW'(w_sel.addr);
                r_wdata <= w_sel.wdata;
                r_cnt   <= '0;
                if (w_sel.rd && w_sel.wr) begin
                    r_err_proto <= 1'b1;
                end
            end else if ((r_state == BUSY) && !bus.mem_done) begin
                r_cnt <= w_cnt_inc;
                // Flag only; the transaction keeps waiting for mem_done
                if (w_to_hit) begin
                    r_err_timeout <= 1'b1;
                end
            end
            if (w_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: table of single
//               transactions plus hand sequences for ties, stall, protocol
//               error, timeout and reset while busy.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        bit          port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        hit;
    } vec_t;

    typedef struct {
        bit          port;
        logic        mrd;
        logic        mwr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        hit;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    vec_t vt[6];

    mem_port_arbiter_if #(.AW(32)) bus ();

    mem_port_arbiter #(.TIMEOUT(20), .AW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.p0_rd = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_rd = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.mem_rdata = '0; bus.mem_done = 1'b0; bus.mem_stall = 1'b0; bus.mem_hit = 1'b0;
    endtask

    task automatic drive_req(input bit port, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            bus.p0_rd = rd; bus.p0_wr = wr; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_rd = rd; bus.p1_wr = wr; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    task automatic drop_req(input bit port);
        if (!port) begin
            bus.p0_rd = 1'b0; bus.p0_wr = 1'b0;
        end else begin
            bus.p1_rd = 1'b0; bus.p1_wr = 1'b0;
        end
    endtask

    // Expected issue for a request: rd+wr together is issued as a read
    task automatic push(input bit port, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic hit);
        exp_t e;
        e.port = port; e.mrd = rd; e.mwr = wr & ~rd;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.hit = hit;
        sb.push_back(e);
    endtask

    task automatic wait_issue(input int max, output int n);
        n = 0;
        while (!(bus.mem_rd || bus.mem_wr) && n < max) begin
            tick();
            n++;
        end
        if (!(bus.mem_rd || bus.mem_wr)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: no mem_rd/mem_wr after %0d cycles, required an issue", max);
        end
    endtask

    // Serve the in-flight transaction: mem_done arrives lat-1 cycles after
    // the issue cycle. to_at>0 checks err_timeout rising exactly at that
    // busy-cycle count.
    task automatic complete(input int lat, input int to_at);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        chk1("busy_issue", bus.busy, 1'b1);
        chk1("grant_issue", bus.grant, e.port);
        chkw("issue_bus", 96'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}),
             96'({e.mrd, e.mwr, e.addr, e.wdata}));
        for (int i = 1; i < lat; i++) begin
            tick();
            chkw("hold_bus", 96'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}),
                 96'({e.mrd, e.mwr, e.addr, e.wdata}));
            chk1("early_done", bus.p0_done | bus.p1_done, 1'b0);
            if (to_at > 0 && i == to_at - 1) chk1("timeout_before", bus.err_timeout, 1'b0);
            if (to_at > 0 && i == to_at)     chk1("timeout_at", bus.err_timeout, 1'b1);
        end
        bus.mem_done = 1'b1; bus.mem_rdata = e.rdata; bus.mem_hit = e.hit;
        #1;
        chk1("p0_done", bus.p0_done, e.port == 1'b0);
        chk1("p1_done", bus.p1_done, e.port == 1'b1);
        if (!e.port) begin
            chk32("p0_rdata", bus.p0_rdata, e.rdata);
            chk1("p0_hit", bus.p0_hit, e.hit);
            chk32("p1_rdata_idle", bus.p1_rdata, 32'h0);
        end else begin
            chk32("p1_rdata", bus.p1_rdata, e.rdata);
            chk1("p1_hit", bus.p1_hit, e.hit);
            chk32("p0_rdata_idle", bus.p0_rdata, 32'h0);
        end
        tick();
        bus.mem_done = 1'b0; bus.mem_rdata = '0; bus.mem_hit = 1'b0;
        drop_req(e.port);
        chk1("bubble_busy", bus.busy, 1'b0);
        chk1("bubble_mem_op", bus.mem_rd | bus.mem_wr, 1'b0);
        chk1("idle_grant", bus.grant, e.port);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        clear_inputs();

        vt[0] = '{port:1'b0, rd:1'b1, wr:1'b0, addr:32'h0000_0040, wdata:32'h0BAD_0BAD, lat:3, rdata:32'h1111_2222, hit:1'b1};
        vt[1] = '{port:1'b1, rd:1'b0, wr:1'b1, addr:32'h0000_6004, wdata:32'hDEAD_BEEF, lat:1, rdata:32'h0, hit:1'b0};
        vt[2] = '{port:1'b0, rd:1'b0, wr:1'b1, addr:32'h0000_0100, wdata:32'hA5A5_A5A5, lat:2, rdata:32'h0, hit:1'b1};
        vt[3] = '{port:1'b1, rd:1'b1, wr:1'b0, addr:32'h0000_2000, wdata:32'h0, lat:4, rdata:32'hCAFE_F00D, hit:1'b1};
        vt[4] = '{port:1'b0, rd:1'b1, wr:1'b0, addr:32'hFFFF_FFFC, wdata:32'h1234_5678, lat:1, rdata:32'hFFFF_FFFF, hit:1'b0};
        vt[5] = '{port:1'b1, rd:1'b1, wr:1'b0, addr:32'h0000_0008, wdata:32'h0, lat:2, rdata:32'h0000_0001, hit:1'b1};

        // Reset state
        tick();
        tick();
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_grant", bus.grant, 1'b1);
        chkw("rst_mem_bus", 96'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 96'h0);
        chk1("rst_done", bus.p0_done | bus.p1_done, 1'b0);
        chk1("rst_err_timeout", bus.err_timeout, 1'b0);
        chk1("rst_err_proto", bus.err_proto, 1'b0);
        rst = 1'b1;
        tick();

        // mem_done while idle produces nothing
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h1234_5678; bus.mem_hit = 1'b1;
        #1;
        chk1("idle_done_p0", bus.p0_done, 1'b0);
        chk1("idle_done_p1", bus.p1_done, 1'b0);
        chk32("idle_rdata_p0", bus.p0_rdata, 32'h0);
        chk1("idle_hit_p0", bus.p0_hit, 1'b0);
        tick();
        chk1("idle_done_busy", bus.busy, 1'b0);
        bus.mem_done = 1'b0; bus.mem_rdata = '0; bus.mem_hit = 1'b0;

        // Table of single-requester transactions
        foreach (vt[k]) begin
            drive_req(vt[k].port, vt[k].rd, vt[k].wr, vt[k].addr, vt[k].wdata);
            push(vt[k].port, vt[k].rd, vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].rdata, vt[k].hit);
            wait_issue(10, n);
            chk32("vec_latency", 32'(n), 32'd1);
            complete(vt[k].lat, 0);
        end

        // Tie after reset: port 0, then port 1 after the bubble, then port 0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0);
        push(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 32'hAAAA_0000, 1'b0);
        push(1'b1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0, 32'hBBBB_0000, 1'b1);
        wait_issue(10, n);
        complete(2, 0);
        wait_issue(10, n);
        chk32("tie_bubble", 32'(n), 32'd1);
        complete(1, 0);
        tick();
        drive_req(1'b0, 1'b0, 1'b1, 32'h0000_0A04, 32'h0000_00A4);
        drive_req(1'b1, 1'b0, 1'b1, 32'h0000_0B04, 32'h0000_00B4);
        push(1'b0, 1'b0, 1'b1, 32'h0000_0A04, 32'h0000_00A4, 32'h0, 1'b0);
        push(1'b1, 1'b0, 1'b1, 32'h0000_0B04, 32'h0000_00B4, 32'h0, 1'b0);
        wait_issue(10, n);
        complete(1, 0);
        wait_issue(10, n);
        complete(2, 0);

        // Stall holds off acceptance; write data held until done
        bus.mem_stall = 1'b1;
        drive_req(1'b1, 1'b0, 1'b1, 32'h0000_6004, 32'hDEAD_BEEF);
        push(1'b1, 1'b0, 1'b1, 32'h0000_6004, 32'hDEAD_BEEF, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("stall_no_issue", bus.mem_rd | bus.mem_wr | bus.busy, 1'b0);
        end
        bus.mem_stall = 1'b0;
        wait_issue(10, n);
        chk32("stall_latency", 32'(n), 32'd1);
        complete(3, 0);

        // rd and wr together: read issued, sticky protocol error
        drive_req(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h5555_AAAA);
        push(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h5555_AAAA, 32'h7777_8888, 1'b1);
        wait_issue(10, n);
        chk1("proto_set", bus.err_proto, 1'b1);
        complete(2, 0);
        chk1("proto_sticky", bus.err_proto, 1'b1);

        // mem_done withheld: timeout rises at 20 busy cycles, stays set
        chk1("timeout_clear", bus.err_timeout, 1'b0);
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        push(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h4444_0000, 1'b0);
        wait_issue(10, n);
        complete(26, 20);
        chk1("timeout_after_done", bus.err_timeout, 1'b1);
        drive_req(1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0);
        push(1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h4444_0004, 1'b1);
        wait_issue(10, n);
        complete(2, 0);
        chk1("timeout_sticky", bus.err_timeout, 1'b1);

        // Reset while busy: abandon, then port 0 wins the re-arbitration
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        push(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h5000_0000, 1'b0);
        wait_issue(10, n);
        complete(1, 0);
        tick();
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
        drive_req(1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
        wait_issue(10, n);
        chk1("rr_before_reset", bus.grant, 1'b1);
        rst = 1'b0;
        tick();
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_mem_rd", bus.mem_rd, 1'b0);
        chk1("mid_rst_done", bus.p0_done | bus.p1_done, 1'b0);
        chk1("mid_rst_errs", bus.err_timeout | bus.err_proto, 1'b0);
        rst = 1'b1;
        sb.delete();
        push(1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h6666_0000, 1'b1);
        push(1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0, 32'h7777_0000, 1'b0);
        wait_issue(10, n);
        chk32("post_rst_latency", 32'(n), 32'd1);
        complete(2, 0);
        wait_issue(10, n);
        complete(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
